fp_norm_round: RTL
==================

FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide: res  input  1  reset, asynchronous, active-low; asserts immediately, releases synchronously to clk.
REQ-003 SHALL provide: in_valid  input  1  upstream big-ALU result valid.
REQ-004 SHALL provide: in_ready  output  1  block accepts a new operand.
REQ-005 SHALL provide: in_sign  input  1  sign of result.
REQ-006 SHALL provide: in_exp  input  8  biased exponent of the larger operand.
REQ-007 SHALL provide: in_sum  input  28  big-ALU magnitude: [27] ignored, [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] sticky.
REQ-008 SHALL provide: out_valid  output  1  result valid.
REQ-009 SHALL provide: out_ready  input  1  downstream accepts result.
REQ-010 SHALL provide: out_result  output  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}.
REQ-011 SHALL provide: out_flags  output  4  {overflow, underflow, zero, inexact}.

Function
REQ-012 SHALL implement states IDLE, NORM, ROUND, RENORM, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; transfer occurs on the edge where in_valid && in_ready, capturing in_sign, in_exp, in_sum[26:0]; state -> NORM.
REQ-014 SHALL hold the exponent internally as 10-bit signed to detect over/underflow without wrap-around.
REQ-015 NORM, sum[26:0]==0: SHALL produce +0 (32'h00000000, sign ignored), zero=1, -> DONE.
REQ-016 NORM, carry=1: SHALL shift right one bit per cycle, new sticky = old guard OR old sticky, exp+1.
REQ-017 NORM, carry=0 and hidden=0: SHALL shift left one bit per cycle (zero into bit 0), exp-1.
REQ-018 NORM, exp would reach 0 on a left shift: SHALL flush to +0 with underflow=1, zero=1, inexact=1, -> DONE (no denormals).
REQ-019 NORM, carry=0 and hidden=1: SHALL go to ROUND with no shift.
REQ-020 ROUND: SHALL round to nearest even: increment at bit 2 iff guard && (sticky || bit2); inexact=1 iff guard||sticky.
REQ-021 ROUND: SHALL go to RENORM if increment sets carry, else DONE.
REQ-022 RENORM: SHALL shift right once, exp+1, -> DONE.
REQ-023 On entry to DONE with exp>=255: SHALL output {sign, 8'hFF, 23'h0}, overflow=1, inexact=1.
REQ-024 Latency: out_valid SHALL assert exactly (number of NORM shifts + 2 + RENORM?1:0) cycles after the accepting edge; maximum 27.
REQ-025 DONE: out_valid=1; out_result and out_flags SHALL remain stable until out_valid && out_ready, then -> IDLE.
REQ-026 SHALL NOT accept a new operand in the cycle of output handshake; earliest next accept is the following cycle.
REQ-027 in_valid and in_sum changes outside IDLE SHALL be ignored.

Reset
REQ-028 res low SHALL force state IDLE, in_ready=1, out_valid=0, out_result=32'h0, out_flags=4'h0, all internal registers zero, at any time including mid-NORM or DONE.
REQ-029 An operation in progress at reset SHALL be discarded, with no output handshake.

Verification
REQ-030 1.0+1.0: in_exp=127, in_sum=28'h4000000 -> out_result=32'h40000000, flags=0, out_valid 3 cycles after accept.
REQ-031 Cancellation: in_exp=127, in_sum=28'h0000004 -> 23 left shifts, out_result=32'h34000000, flags=0, latency 25.
REQ-032 Round carry: in_exp=127, in_sum=28'h3FFFFFF -> RENORM taken, out_result=32'h40000000, inexact=1, latency 3.
REQ-033 Overflow: in_sign=1, in_exp=254, in_sum=28'h4000000 -> out_result=32'hFF800000, overflow=1, inexact=1.
REQ-034 Zero/underflow: in_sum=0 -> 32'h00000000, zero=1; in_exp=3, in_sum=28'h0000004 -> +0, flags=4'b0111.
REQ-035 Backpressure/reset: out_ready=0 for 10 cycles -> out_result stable, out_valid held; res low mid-NORM -> out_valid=0 and in_ready=1 immediately, next operand processed correctly.

Source files
------------

// File: rtl/fp_norm_round_if.sv
// Handshake bundle for the FP normalise/round block.
// master drives operands and out_ready; slave is the block itself.
interface fp_norm_round_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [27:0] in_sum;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   modport master (
      output in_valid, in_sign, in_exp, in_sum, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_sum, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/fp_norm_round.sv
// Multi-cycle normaliser and round-to-nearest-even packer for
// single-precision adder results: one shift per cycle, no denormals.
module fp_norm_round (
   input logic           clk,
   input logic           res,
   fp_norm_round_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, NORM, ROUND, RENORM, DONE
   } state_t;

   state_t             state_q, state_d;
   logic               sign_q, sign_d;
   logic signed [9:0]  exp_q, exp_d;
   logic [26:0]        sum_q, sum_d;
   logic               inexact_q, inexact_d;
   logic [31:0]        result_q, result_d;
   logic [3:0]         flags_q, flags_d;
   logic               inc;
   logic [24:0]        rnd;
   logic               unused_sum;

   assign unused_sum = bus.in_sum[27];

   // Final packing: saturate to signed infinity once exponent reaches 255.
   function automatic logic [35:0] pack(
      input logic              s,
      input logic signed [9:0] e,
      input logic [22:0]       fr,
      input logic              ix
   );
      if (e >= 10'sd255)
         return {s, 8'hFF, 23'h0, 4'b1001};
      return {s, e[7:0], fr, 3'b000, ix};
   endfunction

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q   <= IDLE;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         sum_q     <= '0;
         inexact_q <= 1'b0;
         result_q  <= '0;
         flags_q   <= '0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         sum_q     <= sum_d;
         inexact_q <= inexact_d;
         result_q  <= result_d;
         flags_q   <= flags_d;
      end
   end

   // Next state and datapath: one normalising shift or rounding step per cycle.
   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      sum_d     = sum_q;
      inexact_d = inexact_q;
      result_d  = result_q;
      flags_d   = flags_q;
      inc       = sum_q[1] & (sum_q[0] | sum_q[2]);
      rnd       = {1'b0, sum_q[25:2]} + {24'd0, inc};
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               sign_d    = bus.in_sign;
               exp_d     = {2'b00, bus.in_exp};
               sum_d     = bus.in_sum[26:0];
               inexact_d = 1'b0;
               state_d   = NORM;
            end
         end
         NORM: begin
            if (sum_q == 27'd0) begin
               result_d = 32'h0;
               flags_d  = 4'b0010;
               state_d  = DONE;
            end else if (sum_q[26]) begin
               sum_d = {1'b0, sum_q[26:2], sum_q[1] | sum_q[0]};
               exp_d = exp_q + 10'sd1;
            end else if (!sum_q[25]) begin
               if (exp_q <= 10'sd1) begin
                  result_d = 32'h0;
                  flags_d  = 4'b0111;
                  state_d  = DONE;
               end else begin
                  sum_d = {sum_q[25:0], 1'b0};
                  exp_d = exp_q - 10'sd1;
               end
            end else begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            sum_d     = {rnd, sum_q[1:0]};
            inexact_d = sum_q[1] | sum_q[0];
            if (rnd[24]) begin
               state_d = RENORM;
            end else begin
               {result_d, flags_d} = pack(sign_q, exp_q, rnd[22:0],
                                          sum_q[1] | sum_q[0]);
               state_d = DONE;
            end
         end
         RENORM: begin
            sum_d = {1'b0, sum_q[26:1]};
            exp_d = exp_q + 10'sd1;
            {result_d, flags_d} = pack(sign_q, exp_q + 10'sd1,
                                       sum_q[25:3], inexact_q);
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from state; result held in registers.
   always_comb begin
      bus.in_ready   = (state_q == IDLE);
      bus.out_valid  = (state_q == DONE);
      bus.out_result = result_q;
      bus.out_flags  = flags_q;
   end

endmodule
